x1_lane_sequencer: RTL and testbench

- Transaction sequencer between the neuron-core Wishbone front end and the NUM_LANES Neuromorphic_X1 macros.
- Accepts one command at a time: a read or write, with a lane-enable mask and per-lane write data.
- Issues per-lane strobes, tracks each lane's independent ack, and captures read data per lane.
- Returns one aggregated response, with an optional timeout on non-responding macros.

---
 rtl/x1_lane_sequencer.sv | 162 ++++++++++++++++
 tb/tb_x1_lane_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/x1_lane_sequencer.sv
// Sequences one read/write command across NUM_LANES Neuromorphic_X1 macros and aggregates the acks.
// Optional BUS-state abort timer is compiled in with X1_SEQ_TIMEOUT_EN.
module x1_lane_sequencer #(
    parameter int NUM_LANES      = 4,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    // Both cmd and rsp channels: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable while valid is high and ready is low.
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [NUM_LANES-1:0]    cmd_lane_en,
    input  logic [NUM_LANES*DW-1:0] cmd_dat,
    output logic [NUM_LANES-1:0]    slave_cyc_o,
    output logic [NUM_LANES-1:0]    slave_stb_o,
    output logic                    slave_we_o,
    output logic [NUM_LANES*DW-1:0] slave_dat_o,
    input  logic [NUM_LANES-1:0]    slave_ack_i,
    input  logic [NUM_LANES*DW-1:0] slave_dat_i,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [NUM_LANES*DW-1:0] rsp_dat,
    output logic [NUM_LANES-1:0]    rsp_ack_mask,
    output logic                    rsp_timeout,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [NUM_LANES-1:0]    pending;
    logic [NUM_LANES-1:0]    pending_next;
    logic [NUM_LANES-1:0]    ack_mask;
    logic [NUM_LANES-1:0]    ack_mask_next;
    logic [NUM_LANES*DW-1:0] rdat;
    logic [NUM_LANES*DW-1:0] rdat_next;
    logic                    timeout_q;
    logic                    timeout_next;
    logic                    we_q;
    logic [NUM_LANES*DW-1:0] wdat_q;
    logic [NUM_LANES-1:0]    ack_hit;
    logic                    accept;
    logic                    tmo_hit;

    assign accept  = (state == IDLE) && cmd_valid;
    // Only lanes still pending can complete; duplicates and disabled lanes fall out here.
    assign ack_hit = slave_ack_i & pending;

`ifdef X1_SEQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == BUS) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            pending   <= '0;
            ack_mask  <= '0;
            rdat      <= '0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            wdat_q    <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            ack_mask  <= ack_mask_next;
            rdat      <= rdat_next;
            timeout_q <= timeout_next;
            if (accept) begin
                we_q   <= cmd_we;
                wdat_q <= cmd_dat;
            end
        end
    end

    always_comb begin
        state_next    = state;
        pending_next  = pending;
        ack_mask_next = ack_mask;
        rdat_next     = rdat;
        timeout_next  = timeout_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    ack_mask_next = '0;
                    rdat_next     = '0;
                    timeout_next  = 1'b0;
                    if (cmd_lane_en != '0) begin
                        pending_next = cmd_lane_en;
                        state_next   = BUS;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            BUS: begin
                pending_next  = pending & ~ack_hit;
                ack_mask_next = ack_mask | ack_hit;
                if (!we_q) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (ack_hit[i]) begin
                            rdat_next[i*DW +: DW] = slave_dat_i[i*DW +: DW];
                        end
                    end
                end
                // A final ack landing in the timeout cycle wins over the abort.
                if (pending_next == '0) begin
                    state_next = RESP;
                end else if (tmo_hit) begin
                    pending_next = '0;
                    timeout_next = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
            end
        endcase
    end

    // Strobes are the pending register itself, so they fall asynchronously with reset.
    assign slave_cyc_o  = pending;
    assign slave_stb_o  = pending;
    assign slave_we_o   = we_q;
    assign slave_dat_o  = wdat_q;
    assign cmd_ready    = (state == IDLE);
    assign rsp_valid    = (state == RESP);
    assign rsp_dat      = rdat;
    assign rsp_ack_mask = ack_mask;
    assign rsp_timeout  = timeout_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_x1_lane_sequencer.sv
// Directed bench for x1_lane_sequencer; the timeout cases build only with X1_SEQ_TIMEOUT_EN.
module tb_x1_lane_sequencer;

`ifdef X1_SEQ_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif
    localparam int NL = 4;
    localparam int DW = 32;
    localparam int W  = NL * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [NL-1:0] cmd_lane_en = '0;
    logic [W-1:0]  cmd_dat = '0;
    logic [NL-1:0] slave_cyc_o;
    logic [NL-1:0] slave_stb_o;
    logic          slave_we_o;
    logic [W-1:0]  slave_dat_o;
    logic [NL-1:0] slave_ack_i = '0;
    logic [W-1:0]  slave_dat_i = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_dat;
    logic [NL-1:0] rsp_ack_mask;
    logic          rsp_timeout;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] hold_dat;

    x1_lane_sequencer #(.NUM_LANES(NL), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_lane_en(cmd_lane_en), .cmd_dat(cmd_dat),
        .slave_cyc_o(slave_cyc_o), .slave_stb_o(slave_stb_o), .slave_we_o(slave_we_o),
        .slave_dat_o(slave_dat_o), .slave_ack_i(slave_ack_i), .slave_dat_i(slave_dat_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_ack_mask(rsp_ack_mask), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers a command for one edge; caller must be in IDLE.
    task automatic send_cmd(input logic we, input logic [NL-1:0] en, input logic [W-1:0] dat);
        cmd_valid   = 1'b1;
        cmd_we      = we;
        cmd_lane_en = en;
        cmd_dat     = dat;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic ack(input logic [NL-1:0] lanes, input logic [W-1:0] dat);
        slave_ack_i = lanes;
        slave_dat_i = dat;
        step();
        slave_ack_i = '0;
        slave_dat_i = '0;
    endtask

    task automatic check_rsp(input string tag, input logic [NL-1:0] mask, input logic tmo);
        check({tag, "_valid"}, W'(rsp_valid), W'(1));
        check({tag, "_dat"}, rsp_dat, exp_q.pop_front());
        check({tag, "_mask"}, W'(rsp_ack_mask), W'(mask));
        check({tag, "_tmo"}, W'(rsp_timeout), W'(tmo));
        check({tag, "_stb"}, W'(slave_stb_o), W'(0));
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_idle_rdy"}, W'(cmd_ready), W'(1));
        check({tag, "_idle_busy"}, W'(busy), W'(0));
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_ready", W'(cmd_ready), W'(1));
        check("rst_stb", W'(slave_stb_o), W'(0));
        check("rst_cyc", W'(slave_cyc_o), W'(0));
        check("rst_valid", W'(rsp_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_rdat", rsp_dat, '0);
        check("rst_wdat", slave_dat_o, '0);
        check("rst_tmo", W'(rsp_timeout), W'(0));
        rst = 1'b0;
        step();

        // Read on all lanes, single-cycle acks
        exp_q.push_back({32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000});
        send_cmd(1'b0, 4'hF, '0);
        check("rd4_stb", W'(slave_stb_o), W'(4'hF));
        check("rd4_cyc", W'(slave_cyc_o), W'(4'hF));
        check("rd4_rdy", W'(cmd_ready), W'(0));
        check("rd4_early_valid", W'(rsp_valid), W'(0));
        ack(4'hF, {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000});
        check_rsp("rd4", 4'hF, 1'b0);
        finish_rsp("rd4");

        // Write on lanes 0 and 2 with staggered acks plus spurious lane 1 / duplicate lane 0
        exp_q.push_back('0);
        send_cmd(1'b1, 4'b0101, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        check("wr_dat_o", slave_dat_o, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        check("wr_we_o", W'(slave_we_o), W'(1));
        check("wr_stb1", W'(slave_stb_o), W'(4'b0101));
        ack(4'b0001, {4{32'hBAD0_BAD0}});
        check("wr_stb2", W'(slave_stb_o), W'(4'b0100));
        ack(4'b0011, {4{32'hBAD1_BAD1}});
        check("wr_stb3", W'(slave_stb_o), W'(4'b0100));
        check("wr_mid_valid", W'(rsp_valid), W'(0));
        ack(4'b0100, {4{32'hBAD2_BAD2}});
        check_rsp("wr", 4'b0101, 1'b0);
        finish_rsp("wr");

        // Read with duplicate and disabled-lane acks: first ack data of each enabled lane sticks
        exp_q.push_back({32'h0, 32'hB2B2_2222, 32'h0, 32'hB0B0_0000});
        send_cmd(1'b0, 4'b0101, '0);
        ack(4'b0001, {32'hEEEE_3333, 32'hEEEE_2222, 32'hEEEE_1111, 32'hB0B0_0000});
        ack(4'b1011, {32'hCCCC_3333, 32'hCCCC_2222, 32'hCCCC_1111, 32'hCCCC_0000});
        check("spur_stb", W'(slave_stb_o), W'(4'b0100));
        ack(4'b0100, {32'hDDDD_3333, 32'hB2B2_2222, 32'hDDDD_1111, 32'hDDDD_0000});
        check_rsp("spur", 4'b0101, 1'b0);
        finish_rsp("spur");

        // Empty lane mask goes straight to a response and clears the old read data
        exp_q.push_back('0);
        send_cmd(1'b0, 4'h0, '0);
        check_rsp("empty", 4'h0, 1'b0);
        finish_rsp("empty");

        // Stalled response: fields hold, no new command taken until the handshake
        hold_dat = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        exp_q.push_back(hold_dat);
        send_cmd(1'b0, 4'hF, '0);
        ack(4'hF, hold_dat);
        cmd_valid   = 1'b1;
        cmd_we      = 1'b1;
        cmd_lane_en = 4'b0010;
        cmd_dat     = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        for (int k = 0; k < 5; k++) begin
            check("stall_dat", rsp_dat, hold_dat);
            check("stall_valid", W'(rsp_valid), W'(1));
            check("stall_rdy", W'(cmd_ready), W'(0));
            check("stall_we_o", W'(slave_we_o), W'(0));
            step();
        end
        check_rsp("stall", 4'hF, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("stall_idle_rdy", W'(cmd_ready), W'(1));
        step();
        cmd_valid = 1'b0;
        check("next_stb", W'(slave_stb_o), W'(4'b0010));
        check("next_we_o", W'(slave_we_o), W'(1));
        check("next_dat_o", slave_dat_o, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
        exp_q.push_back('0);
        ack(4'b0010, {4{32'h5555_5555}});
        check_rsp("next", 4'b0010, 1'b0);
        finish_rsp("next");

`ifdef X1_SEQ_TIMEOUT_EN
        // Lane 3 never acks: eight BUS cycles, then abort with the lanes that did answer
        exp_q.push_back({32'h0, 32'h7272, 32'h7171, 32'h7070});
        send_cmd(1'b0, 4'hF, '0);
        check("tmo_stb0", W'(slave_stb_o), W'(4'hF));
        ack(4'b0111, {32'h7373, 32'h7272, 32'h7171, 32'h7070});
        for (int k = 1; k < 8; k++) begin
            check("tmo_stb", W'(slave_stb_o), W'(4'b1000));
            step();
        end
        check_rsp("tmo", 4'b0111, 1'b1);
        finish_rsp("tmo");

        // Ack in the final allowed cycle completes normally
        exp_q.push_back({32'h0, 32'h0, 32'h0, 32'h9999});
        send_cmd(1'b0, 4'b0001, '0);
        for (int k = 0; k < 7; k++) begin
            check("late_stb", W'(slave_stb_o), W'(4'b0001));
            step();
        end
        ack(4'b0001, {32'h0, 32'h0, 32'h0, 32'h9999});
        check_rsp("late", 4'b0001, 1'b0);
        finish_rsp("late");
`endif

        // Reset mid-BUS drops strobes without a clock edge
        send_cmd(1'b0, 4'hF, '0);
        step();
        check("mid_stb_pre", W'(slave_stb_o), W'(4'hF));
        #2;
        rst = 1'b1;
        #1;
        check("mid_stb_rst", W'(slave_stb_o), W'(0));
        check("mid_cyc_rst", W'(slave_cyc_o), W'(0));
        step();
        rst = 1'b0;
        step();
        check("mid_rdy_after", W'(cmd_ready), W'(1));
        check("mid_valid_after", W'(rsp_valid), W'(0));
        check("mid_busy_after", W'(busy), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
